// File: rtl/sos_sample_sequencer_pkg.sv
// sos_sample_sequencer_pkg
//   Shared definitions for the SOS cascade sample sequencer: the 2-bit state
//   encoding, default parameter values and a small state-classification helper.
package sos_sample_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } seq_state_e;

  localparam int SEQ_DATA_SIZE_DEF = 24;
  localparam int SEQ_TIMEOUT_DEF   = 512;
  localparam int SEQ_DROP_W_DEF    = 8;

  // A computation is in flight: a new converter sample cannot be taken.
  function automatic logic in_flight(input seq_state_e s);
    return (s == ST_TRIG) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/sos_sample_sequencer_watchdog.sv
// seq_watchdog
//   Hang detector for the WAIT state. Present only when SEQ_TIMEOUT_EN is
//   defined. Counts enabled cycles from 0 and flags expire on the cycle the
//   count reaches TIMEOUT-1.
//   clk     in   system clock
//   reset   in   asynchronous, active-low reset
//   enable  in   count this cycle
//   clear   in   synchronous return of the count to 0 (has priority)
//   expire  out  enable and count == TIMEOUT-1
`ifdef SEQ_TIMEOUT_EN
module seq_watchdog #(
  parameter int TIMEOUT = 512
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT >= 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = enable && (count_q == CNT_W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/sos_sample_sequencer.sv
// sos_sample_sequencer
//   Initiator side of the SOS cascade handshake. Takes converter samples,
//   holds them on filt_data_in while pulsing sample_trig, waits for a rising
//   edge of the last stage's filter_done, then presents the result to the DAC
//   path. Samples arriving mid-computation are dropped and counted.
//   Optional watchdog on the WAIT state: define SEQ_TIMEOUT_EN.
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   adc_data/adc_valid    incoming sample and its 1-cycle strobe
//   filt_data_in          sample held for the cascade (changes only on accept)
//   sample_trig           1-cycle start pulse to the cascade
//   filt_data_out         cascade result
//   filter_done           cascade completion (level or pulse, rising edge used)
//   dac_data/dac_valid    captured result and its 1-cycle strobe
//   busy                  state != IDLE
//   overrun, drop_cnt     sticky drop flag, saturating drop counter
//   timeout_err           sticky hung-chain flag (0 without SEQ_TIMEOUT_EN)
//   clear_err             synchronous clear of the error state; new events win
//
// state | meaning
// IDLE  | no sample in flight, waiting for adc_valid
// TRIG  | sample latched, sample_trig pulsed this cycle
// WAIT  | cascade computing, watching for filter_done rising edge
// OUT   | dac_valid strobe; may accept the next sample directly
module sos_sample_sequencer
  import sos_sample_sequencer_pkg::*;
#(
  parameter int DATA_SIZE = SEQ_DATA_SIZE_DEF,
  parameter int TIMEOUT   = SEQ_TIMEOUT_DEF,
  parameter int DROP_W    = SEQ_DROP_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] adc_data,
  input  logic                 adc_valid,
  output logic [DATA_SIZE-1:0] filt_data_in,
  output logic                 sample_trig,
  input  logic [DATA_SIZE-1:0] filt_data_out,
  input  logic                 filter_done,
  output logic [DATA_SIZE-1:0] dac_data,
  output logic                 dac_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic [DROP_W-1:0]    drop_cnt,
  output logic                 timeout_err,
  input  logic                 clear_err
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("sos_sample_sequencer: TIMEOUT must be at least 2");
  end

  seq_state_e           state_q, state_d;
  logic                 done_q;
  logic                 done_rise;
  logic [DATA_SIZE-1:0] filt_data_q, filt_data_d;
  logic [DATA_SIZE-1:0] dac_data_q, dac_data_d;
  logic                 overrun_q, overrun_d;
  logic [DROP_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic                 drop_evt;
  logic                 wd_expire;

  assign done_rise = filter_done & ~done_q;
  assign drop_evt  = adc_valid & in_flight(state_q);

  always_comb begin
    state_d     = state_q;
    filt_data_d = filt_data_q;
    dac_data_d  = dac_data_q;
    overrun_d   = clear_err ? 1'b0 : overrun_q;
    drop_cnt_d  = clear_err ? '0 : drop_cnt_q;

    case (state_q)
      ST_IDLE, ST_OUT: begin
        if (adc_valid) begin
          filt_data_d = adc_data;
          state_d     = ST_TRIG;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRIG: state_d = ST_WAIT;
      ST_WAIT: begin
        // A completion on the expiry cycle still counts as a normal result.
        if (done_rise) begin
          dac_data_d = filt_data_out;
          state_d    = ST_OUT;
        end else if (wd_expire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A drop in the same cycle as clear_err leaves the count at exactly one.
    if (drop_evt) begin
      overrun_d = 1'b1;
      if (clear_err) begin
        drop_cnt_d = DROP_W'(1);
      end else if (!(&drop_cnt_q)) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      filt_data_q <= '0;
      dac_data_q  <= '0;
      overrun_q   <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= filter_done;
      filt_data_q <= filt_data_d;
      dac_data_q  <= dac_data_d;
      overrun_q   <= overrun_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic timeout_err_q, timeout_err_d;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == ST_WAIT),
    .clear  (state_q != ST_WAIT),
    .expire (wd_expire)
  );

  always_comb begin
    timeout_err_d = clear_err ? 1'b0 : timeout_err_q;
    if ((state_q == ST_WAIT) && wd_expire && !done_rise) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign filt_data_in = filt_data_q;
  assign dac_data     = dac_data_q;
  assign sample_trig  = (state_q == ST_TRIG);
  assign dac_valid    = (state_q == ST_OUT);
  assign busy         = (state_q != ST_IDLE);
  assign overrun      = overrun_q;
  assign drop_cnt     = drop_cnt_q;

endmodule
